aes128: RTL and testbench
=========================

// Module: aes128
// PURPOSE
//  Iterative AES-128 engine: one round per clock for both the key schedule and the data path.
//  Loads a 128-bit key and expands it once into 11 stored round keys.
//  Then encrypts or decrypts any number of 128-bit blocks with that key.
//  Sits behind a bus/register wrapper; key and data share one input lane upstream.
// PARAMETERS
//  none (localparam NR = 10 rounds, in package)
// PORTS
//  clk_i           in   1    clock; all logic on rising edge
//  rst_ni          in   1    reset; one clock; reset is asynchronous and active-low
//  reset_key_i     in   1    key-load strobe; captures cipher_key_i
//  load_data_i     in   1    data-load strobe; captures plain_text_i and enc_or_dec_i
//  plain_text_i    in   128  input block (plaintext or ciphertext)
//  cipher_key_i    in   128  cipher key
//  enc_or_dec_i    in   1    1 = encrypt, 0 = decrypt; sampled with load_data_i
//  cipher_text_o   out  128  result block
//  cipher_ready_o  out  1    result valid
//  key_ready_o     out  1    round keys valid
// BEHAVIOUR
//  - Byte order, all 128-bit buses: row-major state.
//    - State byte (row r, col c) = bus[127-8*(4r+c) -: 8].
//    - Example: FIPS key 2b7e1516.. appears on the bus as 2B28AB09_7EAEF7CF_...
//  - Reset: cipher_text_o = 0, both ready flags = 0, FSMs idle, round-key store zeroed.
//  - Key FSM, states KIDLE / KEXP:
//    - On an edge with reset_key_i = 1: store the key as rk[0], key_ready_o <= 0, go to KEXP.
//    - KEXP computes rk[1..10], one per cycle (RotWord, SubWord, Rcon 01,02,..,36).
//    - key_ready_o <= 1 on the edge that writes rk[10], i.e. 10 edges after the capture edge.
//    - reset_key_i during KEXP restarts the expansion.
//    - A key load also aborts any data operation in progress; cipher_ready_o <= 0.
//  - Data FSM, states DIDLE / DRUN:
//    - load_data_i is honoured only when key_ready_o = 1; otherwise it is ignored.
//    - On the load edge, encrypt: state <= in ^ rk[0].
//    - On the load edge, decrypt: state <= in ^ rk[10].
//    - On the load edge: cipher_ready_o <= 0, round counter <= 1.
//    - Encrypt rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk[r]).
//    - Encrypt round 10: no MixColumns.
//    - Decrypt rounds 1..9: InvShiftRows, InvSubBytes, AddRoundKey(rk[10-r]), InvMixColumns.
//    - Decrypt round 10: no InvMixColumns; uses rk[0].
//    - Final round edge (10 edges after the load edge):
//      cipher_text_o <= state, cipher_ready_o <= 1, return to DIDLE.
//    - cipher_text_o holds its value until the next completion.
//    - load_data_i while in DRUN restarts the operation with the new input.
//    - reset_key_i and load_data_i on the same edge: key load wins; data load is ignored.
//  - Round keys persist, so repeated blocks need no re-expansion.
//  - Async reset asserted mid-operation: immediate return to reset values.
// CONFIGURATION
//  - AES128_DECRYPT_EN defined: full encrypt/decrypt as above.
//  - Undefined: inverse S-box, InvShiftRows and InvMixColumns are not built.
//    - enc_or_dec_i is ignored; every operation is an encryption.
// STRUCTURE
//  - aes128_pkg: NR, state/word typedefs, sbox/inv_sbox functions, rcon table,
//    xtime/gmul, (inv_)mix_column and (inv_)shift_rows functions.
//  - Sub-module aes128_key_expand: key FSM plus 11x128 round-key store with read port.
//  - Round datapath and data FSM live in the top.
// TESTING
//  - Key load: cipher_key_i = 2B28AB09_7EAEF7CF_15D2154F_16A6883C, pulse reset_key_i 1 cycle.
//    -> key_ready_o = 0 one cycle later; = 1 within 11 cycles of the pulse.
//  - Encrypt: plain_text_i = 4C6D7364_6F20756F_72696D6C_6570206F, enc_or_dec_i = 1, pulse load.
//    -> cipher_ready_o low next cycle, high within 11 cycles.
//    -> cipher_text_o = BFC4C771_D72CD65B_5C4DFAAE_FFF80EDB.
//  - Repeat encrypt twice with no key reload -> identical ciphertext each time, ready toggles low then high.
//  - Reload the same key, then encrypt again -> key_ready_o low then high; same ciphertext.
//  - Decrypt: enc_or_dec_i = 0, input BFC4C771_...0EDB -> cipher_text_o = 4C6D7364_...6570206F.
//  - Negative cases:
//    - load_data_i before key_ready_o -> ignored.
//    - reset_key_i mid-encryption -> cipher_ready_o stays 0.
//    - rst_ni low mid-run -> all outputs 0.

Source files
------------

// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - AES-128 types, GF(2^8) arithmetic and round primitives; inverse ops only with AES128_DECRYPT_EN
package aes128_pkg;
    localparam int NR = 10;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic {KIDLE, KEXP} kstate_e;
    typedef enum logic {DIDLE, DRUN} dstate_e;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic byte_t rotl8(input byte_t a, input int n);
        return byte_t'((a << n) | (a >> (8 - n)));
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
    function automatic byte_t gf_inv(input byte_t a);
        byte_t a2, a3, a12, a15, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic byte_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Buses are row-major, so a column is gathered from four rows
    function automatic word_t get_col(input state_t s, input int c);
        word_t w;
        for (int r = 0; r < 4; r++) w[31-8*r -: 8] = s[127-8*(4*r+c) -: 8];
        return w;
    endfunction

    function automatic state_t set_col(input state_t s, input int c, input word_t w);
        state_t o;
        o = s;
        for (int r = 0; r < 4; r++) o[127-8*(4*r+c) -: 8] = w[31-8*r -: 8];
        return o;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic state_t next_round_key(input state_t k, input logic [3:0] rnd);
        word_t w0, w1, w2, w3, t;
        w3 = get_col(k, 3);
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h0};
        w0 = get_col(k, 0) ^ t;
        w1 = get_col(k, 1) ^ w0;
        w2 = get_col(k, 2) ^ w1;
        w3 = w3 ^ w2;
        return set_col(set_col(set_col(set_col('0, 0, w0), 1, w1), 2, w2), 3, w3);
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r rotates left by r bytes
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        word_t  row;
        for (int r = 0; r < 4; r++) begin
            row = s[127-32*r -: 32];
            o[127-32*r -: 32] = (row << (8*r)) | (row >> (32 - 8*r));
        end
        return o;
    endfunction

    function automatic word_t mix_column(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        o = s;
        for (int c = 0; c < 4; c++) o = set_col(o, c, mix_column(get_col(s, c)));
        return o;
    endfunction

`ifdef AES128_DECRYPT_EN
    function automatic byte_t inv_sbox(input byte_t a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        word_t  row;
        for (int r = 0; r < 4; r++) begin
            row = s[127-32*r -: 32];
            o[127-32*r -: 32] = (row >> (8*r)) | (row << (32 - 8*r));
        end
        return o;
    endfunction

    function automatic word_t inv_mix_column(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        o = s;
        for (int c = 0; c < 4; c++) o = set_col(o, c, inv_mix_column(get_col(s, c)));
        return o;
    endfunction
`endif
endpackage

// File: rtl/aes128_key_expand.sv
// rtl/aes128_key_expand.sv - key FSM, one round key per clock into an 11-entry store with a read port
module aes128_key_expand
    import aes128_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         reset_key_i,
    input  logic [127:0] cipher_key_i,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_key_o,
    output logic         key_ready_o
);
    state_t     rk_q [0:NR];
    state_t     cur_key_q;
    state_t     next_key_d;
    logic [3:0] kcnt_q;
    kstate_e    kstate_q;

    assign next_key_d = next_round_key(cur_key_q, kcnt_q);
    assign rd_key_o   = rk_q[rd_idx_i];

    // Key FSM: capture rk[0], then derive rk[1..10] from the previous key each cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
            cur_key_q   <= '0;
            kcnt_q      <= '0;
            kstate_q    <= KIDLE;
            key_ready_o <= 1'b0;
        end else if (reset_key_i) begin
            rk_q[0]     <= cipher_key_i;
            cur_key_q   <= cipher_key_i;
            kcnt_q      <= 4'd1;
            kstate_q    <= KEXP;
            key_ready_o <= 1'b0;
        end else if (kstate_q == KEXP) begin
            rk_q[kcnt_q] <= next_key_d;
            cur_key_q    <= next_key_d;
            if (kcnt_q == 4'(NR)) begin
                kstate_q    <= KIDLE;
                key_ready_o <= 1'b1;
            end else begin
                kcnt_q <= kcnt_q + 4'd1;
            end
        end
    end
endmodule

// File: rtl/aes128.sv
// rtl/aes128.sv - iterative AES-128 top: data FSM and round datapath; decrypt built only with AES128_DECRYPT_EN
module aes128
    import aes128_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         reset_key_i,
    input  logic         load_data_i,
    input  logic [127:0] plain_text_i,
    input  logic [127:0] cipher_key_i,
    input  logic         enc_or_dec_i,
    output logic [127:0] cipher_text_o,
    output logic         cipher_ready_o,
    output logic         key_ready_o
);
    state_t     state_q;
    state_t     rk_rd;
    state_t     round_d;
    logic [3:0] rnd_q;
    logic [3:0] rd_idx_d;
    logic       load_ok_d;
    logic       last_d;
    dstate_e    dstate_q;

    function automatic state_t enc_round(input state_t s, input state_t k, input logic last);
        state_t t;
        t = shift_rows(sub_bytes(s));
        if (!last) t = mix_columns(t);
        return t ^ k;
    endfunction

    aes128_key_expand u_key_expand (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reset_key_i  (reset_key_i),
        .cipher_key_i (cipher_key_i),
        .rd_idx_i     (rd_idx_d),
        .rd_key_o     (rk_rd),
        .key_ready_o  (key_ready_o)
    );

    // A key load takes priority, so a simultaneous data load is dropped
    assign load_ok_d = load_data_i && key_ready_o && !reset_key_i;
    assign last_d    = (rnd_q == 4'(NR));

`ifdef AES128_DECRYPT_EN
    logic enc_q;

    function automatic state_t dec_round(input state_t s, input state_t k, input logic last);
        state_t t;
        t = inv_sub_bytes(inv_shift_rows(s)) ^ k;
        if (!last) t = inv_mix_columns(t);
        return t;
    endfunction

    // Decryption walks the key store backwards, starting from rk[10]
    assign rd_idx_d = load_ok_d ? (enc_or_dec_i ? 4'd0 : 4'(NR))
                                : (enc_q ? rnd_q : 4'(NR) - rnd_q);
    assign round_d  = enc_q ? enc_round(state_q, rk_rd, last_d)
                            : dec_round(state_q, rk_rd, last_d);

    // Direction is latched with each accepted block
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        enc_q <= 1'b1;
        else if (load_ok_d) enc_q <= enc_or_dec_i;
    end
`else
    logic unused_enc;
    assign unused_enc = enc_or_dec_i;
    assign rd_idx_d   = load_ok_d ? 4'd0 : rnd_q;
    assign round_d    = enc_round(state_q, rk_rd, last_d);
`endif

    // Data FSM: initial AddRoundKey on load, then one round per clock, result on round 10
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= '0;
            rnd_q          <= '0;
            dstate_q       <= DIDLE;
            cipher_text_o  <= '0;
            cipher_ready_o <= 1'b0;
        end else if (reset_key_i) begin
            dstate_q       <= DIDLE;
            cipher_ready_o <= 1'b0;
        end else if (load_ok_d) begin
            state_q        <= plain_text_i ^ rk_rd;
            rnd_q          <= 4'd1;
            dstate_q       <= DRUN;
            cipher_ready_o <= 1'b0;
        end else if (dstate_q == DRUN) begin
            if (last_d) begin
                cipher_text_o  <= round_d;
                cipher_ready_o <= 1'b1;
                dstate_q       <= DIDLE;
            end else begin
                state_q <= round_d;
                rnd_q   <= rnd_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes128.sv
// tb/tb_aes128.sv - randomized self-checking bench for aes128 against a byte-array AES model
module tb_aes128;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         reset_key;
    logic         load_data;
    logic         enc;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic         cr;
    logic         kr;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];
    logic [7:0] ek  [176];

    localparam logic [127:0] FIPS_KEY = 128'h2B28AB09_7EAEF7CF_15D2154F_16A6883C;
    localparam logic [127:0] LOREM_PT = 128'h4C6D7364_6F20756F_72696D6C_6570206F;
    localparam logic [127:0] LOREM_CT = 128'hBFC4C771_D72CD65B_5C4DFAAE_FFF80EDB;

    always #5 clk = ~clk;

    aes128 dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reset_key_i    (reset_key),
        .load_data_i    (load_data),
        .plain_text_i   (pt),
        .cipher_key_i   (key),
        .enc_or_dec_i   (enc),
        .cipher_text_o  (ct),
        .cipher_ready_o (cr),
        .key_ready_o    (kr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less product then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h011b << (k - 8));
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic model_key(input logic [127:0] k);
        logic [7:0] tmp [4];
        logic [7:0] rc, t0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ek[r+4*c] = k[127-8*(4*r+c) -: 8];
        rc = 8'h01;
        for (int w = 4; w < 44; w++) begin
            for (int j = 0; j < 4; j++) tmp[j] = ek[4*(w-1)+j];
            if (w % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[t0];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) ek[4*w+j] = ek[4*(w-4)+j] ^ tmp[j];
        end
    endtask

    task automatic mix(inout logic [7:0] s [16], input bit inverse);
        logic [7:0] coef [4];
        logic [7:0] t [16];
        coef = inverse ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
        t = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                s[4*c+r] = 8'h00;
                for (int j = 0; j < 4; j++) s[4*c+r] = s[4*c+r] ^ gm(coef[(j-r+4)%4], t[4*c+j]);
            end
    endtask

    task automatic model_crypt(input bit enc_m, input logic [127:0] din, output logic [127:0] dout);
        logic [7:0] s [16];
        logic [7:0] t [16];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r+4*c] = din[127-8*(4*r+c) -: 8];
        if (enc_m) begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[i];
            for (int rnd = 1; rnd <= 10; rnd++) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                t = s;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
                if (rnd < 10) mix(s, 1'b0);
                for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[16*rnd+i];
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[160+i];
            for (int rnd = 9; rnd >= 0; rnd--) begin
                t = s;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) s[r+4*((c+r)%4)] = t[r+4*c];
                for (int i = 0; i < 16; i++) s[i] = isb[s[i]] ^ ek[16*rnd+i];
                if (rnd > 0) mix(s, 1'b1);
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) dout[127-8*(4*r+c) -: 8] = s[r+4*c];
    endtask

    function automatic bit eff_enc(input bit e);
`ifdef AES128_DECRYPT_EN
        return e;
`else
        return e | 1'b1;
`endif
    endfunction

    task automatic load_key(input string tag, input logic [127:0] k);
        int n;
        @(negedge clk);
        key = k;
        reset_key = 1'b1;
        @(negedge clk);
        reset_key = 1'b0;
        model_key(k);
        check({tag, "_kr_low"}, 128'(kr), 128'(0));
        n = 0;
        while (!kr && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_kr_latency"}, 128'(n), 128'(10));
    endtask

    task automatic start(input logic [127:0] d, input bit e);
        @(negedge clk);
        pt = d;
        enc = e;
        load_data = 1'b1;
        @(negedge clk);
        load_data = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [127:0] d, input bit e, output logic [127:0] res);
        int n;
        logic [127:0] exp;
        start(d, e);
        check({tag, "_cr_low"}, 128'(cr), 128'(0));
        n = 0;
        while (!cr && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(10));
        model_crypt(eff_enc(e), d, exp);
        check({tag, "_data"}, ct, exp);
        res = ct;
    endtask

    initial begin
        logic [127:0] res, res2, d1, d2, exp;
        rst_n = 1'b0;
        reset_key = 1'b0;
        load_data = 1'b0;
        enc = 1'b1;
        pt = '0;
        key = '0;
        build_tables();
        repeat (3) @(negedge clk);
        check("rst_ct", ct, 128'(0));
        check("rst_cr", 128'(cr), 128'(0));
        check("rst_kr", 128'(kr), 128'(0));
        rst_n = 1'b1;

        start(LOREM_PT, 1'b1);
        repeat (12) @(negedge clk);
        check("nokey_cr", 128'(cr), 128'(0));
        check("nokey_ct", ct, 128'(0));

        load_key("fips", FIPS_KEY);
        run_block("enc1", LOREM_PT, 1'b1, res);
        check("enc1_vector", res, LOREM_CT);
        repeat (3) @(negedge clk);
        check("enc1_hold", ct, LOREM_CT);
        run_block("enc2", LOREM_PT, 1'b1, res2);
        check("enc2_same", res2, res);
        load_key("reload", FIPS_KEY);
        run_block("enc3", LOREM_PT, 1'b1, res2);
        check("enc3_same", res2, LOREM_CT);
        run_block("dec1", LOREM_CT, 1'b0, res);
`ifdef AES128_DECRYPT_EN
        check("dec1_vector", res, LOREM_PT);
`endif

        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) load_key("rkey", {$urandom, $urandom, $urandom, $urandom});
            run_block("rand", {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), res);
        end

        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        start(d1, 1'b1);
        repeat (4) @(negedge clk);
        run_block("restart", d2, 1'b0, res);
        res2 = ct;

        @(negedge clk);
        key = FIPS_KEY;
        reset_key = 1'b1;
        load_data = 1'b1;
        pt = d1;
        @(negedge clk);
        reset_key = 1'b0;
        load_data = 1'b0;
        model_key(FIPS_KEY);
        check("same_edge_kr", 128'(kr), 128'(0));
        check("same_edge_cr", 128'(cr), 128'(0));
        repeat (13) @(negedge clk);
        check("same_edge_kr_up", 128'(kr), 128'(1));
        check("same_edge_cr_idle", 128'(cr), 128'(0));

        start(d1, 1'b1);
        repeat (3) @(negedge clk);
        load_key("abort", FIPS_KEY);
        repeat (5) @(negedge clk);
        check("abort_cr", 128'(cr), 128'(0));
        check("abort_ct_hold", ct, res2);
        run_block("after_abort", d1, 1'b1, res);
        model_crypt(1'b1, d1, exp);
        check("after_abort_model", res, exp);

        start(d2, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ct", ct, 128'(0));
        check("arst_cr", 128'(cr), 128'(0));
        check("arst_kr", 128'(kr), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        start(d2, 1'b1);
        repeat (12) @(negedge clk);
        check("arst_nokey_cr", 128'(cr), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
